sort_memory: RTL
================

# sort_memory

Word-addressed memory slave that serves the insertion-sort controller's AXI-style handshakes. It sits directly downstream of the sort controller and its datapath, accepting read requests on AR, returning data on R, and accepting writes on AW/W with a response on B. It holds the array being sorted and returns SLVERR on out-of-range writes, which drives the controller's `error` path. The read latency is configurable so the bench can stress the controller's wait behaviour.

## Interface
- `ADDR_WDTH`, 4, address width in words.
- `DATA_WDTH`, 32, word width.
- `RESP_WDTH`, 1, B response width; 0 = OKAY, 1 = SLVERR.
- `MEM_DEPTH`, 16, number of implemented words; must be ≤ 2^ADDR_WDTH.
- `READ_LAT`, 1, cycles from AR handshake to `r_valid`; must be ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ar_valid`  in  1  read request valid.
- `ar_ready`  out  1  read request accepted.
- `ar_addr`  in  ADDR_WDTH  read word address.
- `r_valid`  out  1  read data valid.
- `r_ready`  in  1  read data consumed.
- `r_data`  out  DATA_WDTH  read data.
- `aw_valid`  in  1  write address valid.
- `aw_ready`  out  1  write address accepted.
- `aw_addr`  in  ADDR_WDTH  write word address.
- `w_valid`  in  1  write data valid.
- `w_ready`  out  1  write data accepted.
- `w_data`  in  DATA_WDTH  write data.
- `b_valid`  out  1  write response valid.
- `b_ready`  in  1  write response consumed.
- `b_resp`  out  RESP_WDTH  write response.

## Operation
- Storage is MEM_DEPTH × DATA_WDTH registers. All words reset to 0.
- Read FSM has three states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: `ar_ready` = 1. On `ar_valid`, the handshake occurs. The addressed word is latched into `r_data` from pre-edge contents; an out-of-range address latches 0. A latency counter loads READ_LAT−1.
  - From R_IDLE, go to R_DATA if READ_LAT = 1, otherwise to R_WAIT.
  - R_WAIT: count down; at 0, go to R_DATA.
  - R_DATA: `r_valid` = 1 and `r_data` is stable until `r_ready`. On the handshake, return to R_IDLE. No back-to-back AR acceptance in the same cycle.
- Write path has three flags: `aw_got`, `w_got`, `b_pend`.
  - `aw_ready = !aw_got && !b_pend`; `w_ready = !w_got && !b_pend`.
  - AW and W are accepted independently, in either order or in the same cycle. Address and data are buffered.
  - Commit happens on the edge where both are held, counting same-cycle handshakes. In range: write the word, `b_resp` = 0. Out of range: no write, `b_resp` = 1. Clear `aw_got`/`w_got`, set `b_pend`.
  - `b_valid = b_pend`; `b_resp` is stable until `b_ready`. The handshake clears `b_pend`.
- Read/write hazard: a read whose AR handshake shares the commit edge returns the old value. A later AR returns the new value.
- Reset at any time, mid-read or mid-write, aborts everything:
  - All outputs return to their reset values.
  - Buffered AW/W are discarded.
  - Memory clears to 0.
- Outputs are X-free after reset.

## Timing
- Reset values: `ar_ready` = 1, `aw_ready` = 1, `w_ready` = 1, `r_valid` = 0, `r_data` = 0, `b_valid` = 0, `b_resp` = 0.
- Read: AR handshake in cycle t gives `r_valid` high from cycle t+READ_LAT until the R handshake. `ar_ready` is low from t+1 until the cycle after the R handshake.
- Write:
  - AW and W handshake in cycle t: `b_valid` high from t+1.
  - AW at t1, W at t2 > t1 (or the reverse): `b_valid` from max(t1, t2)+1.
  - `aw_ready`/`w_ready` are low while `b_valid` is high, and go high the cycle after the B handshake.
- Read and write channels are fully concurrent. Neither stalls the other.
- Valid/ready rules are sampled at the rising edge. Slave outputs never depend combinationally on master valids.

## Test plan
- Reset then idle: all outputs hold their reset values; reading address 5 returns 0 at t+1 (READ_LAT = 1).
- Write then read: AW 3 and W 0xDEADBEEF in the same cycle t gives `b_valid` at t+1 with `b_resp` = 0. A later read of address 3 returns 0xDEADBEEF.
- Split write:
  - W 0x11 at cycle 10, AW 7 at cycle 14: `b_valid` at 15.
  - Hold `b_ready` low for 3 cycles: `aw_ready`/`w_ready` stay 0 and `b_resp` stays 0.
  - Read of address 7 returns 0x11.
- Out-of-range (MEM_DEPTH = 12): a write to address 13 gives `b_resp` = 1 and memory is unchanged; a read of address 13 returns 0.
- Latency/backpressure (READ_LAT = 3): AR at t gives `r_valid` at t+3. With `r_ready` low for 4 cycles, `r_data` stays stable and `ar_ready` stays 0.
- Hazard and reset:
  - AR 2 on the same edge as a commit of 0x55 to address 2 returns the old value; the next read returns 0x55.
  - Asserting `rst` while R_WAIT and `b_pend` are active gives immediate reset values and memory all 0.

Source files
------------

// File: rtl/sort_memory.sv
// Word-addressed memory slave with AXI-style AR/R and AW/W/B channels.
// Reads have a fixed, configurable latency. Out-of-range writes are dropped and answered with SLVERR.
module sort_memory #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1,
   parameter int MEM_DEPTH = 16,
   parameter int READ_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ar_valid,
   output logic                 ar_ready,
   input  logic [ADDR_WDTH-1:0] ar_addr,
   output logic                 r_valid,
   input  logic                 r_ready,
   output logic [DATA_WDTH-1:0] r_data,
   input  logic                 aw_valid,
   output logic                 aw_ready,
   input  logic [ADDR_WDTH-1:0] aw_addr,
   input  logic                 w_valid,
   output logic                 w_ready,
   input  logic [DATA_WDTH-1:0] w_data,
   output logic                 b_valid,
   input  logic                 b_ready,
   output logic [RESP_WDTH-1:0] b_resp
);

   localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(READ_LAT - 1);
   localparam logic [ADDR_WDTH:0] DEPTH_L  = (ADDR_WDTH + 1)'(MEM_DEPTH);

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } r_state_t;

   r_state_t             r_state_reg, r_state_next;
   logic [CNT_W-1:0]     lat_cnt_reg, lat_cnt_next;
   logic [DATA_WDTH-1:0] r_data_reg, r_data_next;
   logic [DATA_WDTH-1:0] rd_word;

   logic [DATA_WDTH-1:0] mem_reg [MEM_DEPTH];
   logic [MEM_DEPTH-1:0] word_we;

   logic                 aw_got_reg, w_got_reg, b_pend_reg;
   logic [ADDR_WDTH-1:0] aw_addr_reg;
   logic [DATA_WDTH-1:0] w_data_reg;
   logic [RESP_WDTH-1:0] b_resp_reg;

   logic                 aw_hs, w_hs, commit, in_range;
   logic [ADDR_WDTH-1:0] wr_addr;
   logic [DATA_WDTH-1:0] wr_data;

   // ---------------- write channel ----------------
   assign aw_ready = !aw_got_reg && !b_pend_reg;
   assign w_ready  = !w_got_reg && !b_pend_reg;
   assign b_valid  = b_pend_reg;
   assign b_resp   = b_resp_reg;

   assign aw_hs = aw_valid && aw_ready;
   assign w_hs  = w_valid && w_ready;

   // A handshake in the commit cycle itself bypasses the buffer
   assign wr_addr  = aw_got_reg ? aw_addr_reg : aw_addr;
   assign wr_data  = w_got_reg ? w_data_reg : w_data;
   assign commit   = (aw_got_reg || aw_hs) && (w_got_reg || w_hs);
   assign in_range = {1'b0, wr_addr} < DEPTH_L;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_got_reg  <= 1'b0;
         w_got_reg   <= 1'b0;
         b_pend_reg  <= 1'b0;
         aw_addr_reg <= '0;
         w_data_reg  <= '0;
         b_resp_reg  <= '0;
      end else begin
         if (b_pend_reg && b_ready) begin
            b_pend_reg <= 1'b0;
         end
         if (commit) begin
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
            b_pend_reg <= 1'b1;
            b_resp_reg <= in_range ? '0 : RESP_WDTH'(1);
         end else begin
            if (aw_hs) begin
               aw_got_reg  <= 1'b1;
               aw_addr_reg <= aw_addr;
            end
            if (w_hs) begin
               w_got_reg  <= 1'b1;
               w_data_reg <= w_data;
            end
         end
      end
   end

   // ---------------- storage ----------------
   // Addresses at or beyond MEM_DEPTH match no word, so they neither write nor read
   generate
      for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_we
         assign word_we[gi] = commit && (wr_addr == ADDR_WDTH'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            if (word_we[i]) begin
               mem_reg[i] <= wr_data;
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         if (ar_addr == ADDR_WDTH'(i)) begin
            rd_word = mem_reg[i];
         end
      end
   end

   // ---------------- read channel ----------------
   assign ar_ready = (r_state_reg == R_IDLE);
   assign r_valid  = (r_state_reg == R_DATA);
   assign r_data   = r_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_reg <= R_IDLE;
         lat_cnt_reg <= '0;
         r_data_reg  <= '0;
      end else begin
         r_state_reg <= r_state_next;
         lat_cnt_reg <= lat_cnt_next;
         r_data_reg  <= r_data_next;
      end
   end

   always_comb begin
      r_state_next = r_state_reg;
      lat_cnt_next = lat_cnt_reg;
      r_data_next  = r_data_reg;
      case (r_state_reg)
         R_IDLE: begin
            if (ar_valid) begin
               r_data_next  = rd_word;
               lat_cnt_next = CNT_LOAD;
               r_state_next = (READ_LAT == 1) ? R_DATA : R_WAIT;
            end
         end
         R_WAIT: begin
            // Leave when the count is about to expire so r_valid lands exactly READ_LAT cycles after AR
            lat_cnt_next = lat_cnt_reg - 1'b1;
            if (lat_cnt_reg <= CNT_W'(1)) begin
               r_state_next = R_DATA;
            end
         end
         R_DATA: begin
            if (r_ready) begin
               r_state_next = R_IDLE;
            end
         end
         default: begin
            r_state_next = R_IDLE;
         end
      endcase
   end

endmodule
